fog_mod_gen: RTL
================

Name: fog_mod_gen

Overview:
- Square-wave phase-modulation generator for the FOG loop.
- Sits directly downstream of the Avalon gyro variable register bank and consumes its modulation registers: freq count, mod high, mod low, mod off, init stable count, and a sample delay.
- Drives the modulation DAC code and emits half-period edge and ADC sample strobes for the demodulator.
- Register values are shadowed and applied only at full-period boundaries, so software writes never produce a truncated half-period.

Parameters:
- DATA_W, 32, width of register-bank inputs.
- DAC_W, 16, width of the signed modulation DAC code.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_freq_cnt  in  DATA_W  half-period length in clk cycles, unsigned; valid when >= 2.
- i_mod_H  in  DATA_W  signed high-level modulation code.
- i_mod_L  in  DATA_W  signed low-level modulation code.
- i_mod_off  in  DATA_W  bit0=1 disables modulation; other bits ignored.
- i_stable_cnt  in  DATA_W  number of half-periods after start before o_stable asserts.
- i_smp_dly  in  DATA_W  clk cycles after each half-period edge before the sample strobe.
- o_mod_dac  out  DAC_W  signed DAC code, registered.
- o_mod_phase  out  1  0 = high half, 1 = low half.
- o_half_edge  out  1  one-cycle pulse on the first cycle of each half-period.
- o_smp_stb  out  1  one-cycle ADC sample strobe.
- o_stable  out  1  modulation settled.
- o_cfg_err  out  1  i_freq_cnt < 2 while enabled.

Behaviour:
- All outputs are registered. Synchronous reset (rst_n=0 at a clk edge) forces all outputs to 0, state=IDLE, counters=0, shadows=0. This applies mid-operation as well.
- States: IDLE, RUN_H, RUN_L.
- IDLE:
  - o_mod_dac=0, o_stable=0, stable counter cleared.
  - o_cfg_err <= (i_mod_off[0]==0 && i_freq_cnt<2).
  - If i_mod_off[0]==0 and i_freq_cnt>=2, at the next edge: load shadows (freq, H, L, smp_dly), cnt<=0, state<=RUN_H, o_mod_dac<=sat(H), o_mod_phase<=0, o_half_edge<=1.
- RUN_H / RUN_L:
  - cnt increments each cycle.
  - When cnt==shadow_freq-1: cnt<=0, o_half_edge<=1.
  - RUN_H -> RUN_L: o_mod_dac<=sat(shadow_L), o_mod_phase<=1.
  - RUN_L -> RUN_H (full-period boundary): reload all shadows from inputs first, then o_mod_dac<=sat(new H), o_mod_phase<=0.
  - If the reloaded i_freq_cnt<2, go to IDLE instead and set o_cfg_err=1 at that edge.
- Resulting cadence: a half-period is exactly shadow_freq cycles of a constant DAC code, and o_half_edge pulses every shadow_freq cycles.
- Sample strobe:
  - o_smp_stb=1 in the cycle the registered cnt equals shadow_smp_dly; one pulse per half-period.
  - If shadow_smp_dly >= shadow_freq, no strobe is produced.
  - With smp_dly=0, the strobe coincides with o_half_edge.
- Stable counter:
  - Increments on each o_half_edge while running and saturates at all-ones.
  - o_stable=1 when count >= i_stable_cnt.
  - i_stable_cnt=0 gives o_stable=1 from the first RUN_H cycle.
- mod_off:
  - i_mod_off[0]=1 in any RUN state takes effect immediately: next edge -> IDLE, o_mod_dac=0, o_half_edge=0, o_smp_stb=0, o_stable=0.
  - This overrides a simultaneous half-period boundary.
- Saturation sat(x): x is treated as signed DATA_W.
  - x > 2^(DAC_W-1)-1 gives 0x7FFF.
  - x < -2^(DAC_W-1) gives 0x8000.
  - Otherwise x[DAC_W-1:0].
- Input changes between boundaries never affect the current period, except i_mod_off, which is immediate.
- Counter width is DATA_W. Wrap-around is impossible because cnt resets at shadow_freq-1.

Decomposition:
- Shared package fog_mod_pkg: state enum (IDLE, RUN_H, RUN_L), DAC_W default, the signed saturate function sat_to_dac, and the MOD_OFF_BIT=0 constant.
- No sub-module needed. The saturation function is shared with the future feedback-ladder block, which is why it lives in the package.

Test Plan:
- Basic waveform: freq_cnt=4, H=100, L=-100, mod_off=0, after reset. Required: o_mod_dac sequence 100,100,100,100,-100,-100,-100,-100 repeating; o_half_edge pulse every 4 cycles; o_mod_phase toggles with it.
- Shadowing: during the 2nd cycle of RUN_H, write freq_cnt=6 and H=200. Required: the current H and L halves stay 4 cycles at 100/-100; the next H half is 6 cycles at 200.
- Saturation: H=32'h0001_0000, L=32'hFFFE_0000. Required: dac 0x7FFF then 0x8000.
- Sample strobe: freq_cnt=4 with smp_dly=2. Required: o_smp_stb pulses exactly 2 cycles after each o_half_edge. With smp_dly=5, no strobe ever fires.
- Stable counter: stable_cnt=3. Required: o_stable rises in the cycle after the 3rd o_half_edge. Then assert mod_off mid-half: next cycle dac=0, o_stable=0, state IDLE. Deassert: restart with a half-edge at H.
- Config error and reset: freq_cnt=1 with mod_off=0 keeps the block in IDLE with o_cfg_err=1. Setting freq_cnt=1 mid-run drops to IDLE at the next L->H boundary. rst_n=0 for one edge mid-run clears every output the following cycle.

Source files
------------

// File: rtl/fog_mod_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : fog_mod_pkg                                               |
// | Purpose  : Shared types, constants and the signed DAC saturation     |
// |            helper for the FOG modulation / feedback blocks.          |
// | Contents : mod_state_t   - modulation generator state encoding       |
// |            DAC_W_DEFAULT - default DAC code width                    |
// |            MOD_OFF_BIT   - bit of the mod-off register that disables |
// |            sat_to_dac()  - clamp a signed value into a DAC range     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fog_mod_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN_H = 2'd1,
      RUN_L = 2'd2
   } mod_state_t;

   localparam int DAC_W_DEFAULT = 16;
   localparam int MOD_OFF_BIT   = 0;

   // Clamp a sign-extended value into the signed range of a dac_w-bit code.
   // The result is returned 64 bits wide; callers truncate it to dac_w bits,
   // which yields 0x7F..F / 0x80..0 / x[dac_w-1:0] as appropriate. Working at
   // 64 bits lets the feedback ladder reuse this with a different DAC width.
   function automatic logic [63:0] sat_to_dac(input logic signed [63:0] x,
                                              input int                 dac_w);
      logic signed [63:0] lim;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      lim   = 64'sd1 <<< (dac_w - 1);
      max_v = lim - 64'sd1;
      min_v = -lim;
      if (x > max_v) begin
         return max_v;
      end else if (x < min_v) begin
         return min_v;
      end else begin
         return x;
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/fog_mod_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fog_mod_gen                                               |
// | Purpose  : Square-wave phase-modulation generator for the FOG loop.  |
// |            Produces a two-level DAC code with shadowed register      |
// |            values applied only at full-period (L->H) boundaries,     |
// |            plus half-period edge and ADC sample strobes.             |
// | Ports    : clk, rst_n          - clock, synchronous active-low reset  |
// |            i_freq_cnt          - half-period length (cycles, >= 2)    |
// |            i_mod_H / i_mod_L   - signed high / low modulation codes   |
// |            i_mod_off           - bit0 = 1 disables modulation         |
// |            i_stable_cnt        - half-periods before o_stable         |
// |            i_smp_dly           - edge-to-sample delay in cycles       |
// |            o_mod_dac           - saturated signed DAC code            |
// |            o_mod_phase         - 0 high half, 1 low half              |
// |            o_half_edge         - first cycle of each half-period      |
// |            o_smp_stb           - ADC sample strobe                    |
// |            o_stable            - modulation settled                   |
// |            o_cfg_err           - freq count < 2 while enabled         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fog_mod_gen
   import fog_mod_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DAC_W  = DAC_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_freq_cnt,
   input  logic [DATA_W-1:0] i_mod_H,
   input  logic [DATA_W-1:0] i_mod_L,
   input  logic [DATA_W-1:0] i_mod_off,
   input  logic [DATA_W-1:0] i_stable_cnt,
   input  logic [DATA_W-1:0] i_smp_dly,
   output logic [DAC_W-1:0]  o_mod_dac,
   output logic              o_mod_phase,
   output logic              o_half_edge,
   output logic              o_smp_stb,
   output logic              o_stable,
   output logic              o_cfg_err
);

   mod_state_t        state;
   logic [DATA_W-1:0] cnt;
   logic [DATA_W-1:0] sh_freq;
   logic [DATA_W-1:0] sh_dly;
   logic [DAC_W-1:0]  sh_l;      // low level kept already saturated
   logic [DATA_W-1:0] stab;

   logic              mod_off;
   logic              freq_ok;
   logic              cnt_last;
   logic [DATA_W-1:0] stab_next;
   logic [DAC_W-1:0]  sat_h_in;
   logic [DAC_W-1:0]  sat_l_in;
   logic              unused_mod_off;

   // Only bit 0 of the mod-off register carries meaning.
   assign unused_mod_off = ^{i_mod_off[DATA_W-1:MOD_OFF_BIT+1]};

   always_comb begin
      mod_off  = i_mod_off[MOD_OFF_BIT];
      freq_ok  = (i_freq_cnt >= DATA_W'(2));
      cnt_last = (cnt == sh_freq - DATA_W'(1));
      sat_h_in = DAC_W'(sat_to_dac(64'($signed(i_mod_H)), DAC_W));
      sat_l_in = DAC_W'(sat_to_dac(64'($signed(i_mod_L)), DAC_W));
      // o_half_edge is high exactly in the first cycle of a half-period, so
      // counting it at the closing edge of that cycle counts half-periods.
      stab_next = stab;
      if (o_half_edge && !(&stab)) begin
         stab_next = stab + DATA_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         sh_freq     <= '0;
         sh_dly      <= '0;
         sh_l        <= '0;
         stab        <= '0;
         o_mod_dac   <= '0;
         o_mod_phase <= 1'b0;
         o_half_edge <= 1'b0;
         o_smp_stb   <= 1'b0;
         o_stable    <= 1'b0;
         o_cfg_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt         <= '0;
               stab        <= '0;
               o_mod_dac   <= '0;
               o_mod_phase <= 1'b0;
               o_half_edge <= 1'b0;
               o_smp_stb   <= 1'b0;
               o_stable    <= 1'b0;
               o_cfg_err   <= !mod_off && !freq_ok;
               if (!mod_off && freq_ok) begin
                  state       <= RUN_H;
                  sh_freq     <= i_freq_cnt;
                  sh_l        <= sat_l_in;
                  sh_dly      <= i_smp_dly;
                  o_mod_dac   <= sat_h_in;
                  o_half_edge <= 1'b1;
                  o_smp_stb   <= (i_smp_dly == '0);
                  // stable count is still zero on the first RUN_H cycle
                  o_stable    <= (i_stable_cnt == '0);
               end
            end

            RUN_H, RUN_L: begin
               if (mod_off) begin
                  // mod-off wins over any coincident half-period boundary
                  state       <= IDLE;
                  cnt         <= '0;
                  stab        <= '0;
                  o_mod_dac   <= '0;
                  o_mod_phase <= 1'b0;
                  o_half_edge <= 1'b0;
                  o_smp_stb   <= 1'b0;
                  o_stable    <= 1'b0;
                  o_cfg_err   <= 1'b0;
               end else begin
                  stab      <= stab_next;
                  o_cfg_err <= 1'b0;
                  o_stable  <= (stab_next >= i_stable_cnt);
                  if (!cnt_last) begin
                     cnt         <= cnt + DATA_W'(1);
                     o_half_edge <= 1'b0;
                     o_smp_stb   <= (cnt + DATA_W'(1) == sh_dly);
                  end else if (state == RUN_H) begin
                     cnt         <= '0;
                     state       <= RUN_L;
                     o_mod_dac   <= sh_l;
                     o_mod_phase <= 1'b1;
                     o_half_edge <= 1'b1;
                     o_smp_stb   <= (sh_dly == '0);
                  end else begin
                     // full-period boundary: pick up new register values
                     cnt     <= '0;
                     sh_freq <= i_freq_cnt;
                     sh_l    <= sat_l_in;
                     sh_dly  <= i_smp_dly;
                     if (!freq_ok) begin
                        state       <= IDLE;
                        stab        <= '0;
                        o_mod_dac   <= '0;
                        o_mod_phase <= 1'b0;
                        o_half_edge <= 1'b0;
                        o_smp_stb   <= 1'b0;
                        o_stable    <= 1'b0;
                        o_cfg_err   <= 1'b1;
                     end else begin
                        state       <= RUN_H;
                        o_mod_dac   <= sat_h_in;
                        o_mod_phase <= 1'b0;
                        o_half_edge <= 1'b1;
                        o_smp_stb   <= (i_smp_dly == '0);
                     end
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
